// File: rtl/dma_h2c_crdt_pkg.sv
// Shared widths and types for the credit-gated H2C stream transmitter.
// The byte-parity helper is used on the input side of the output register.
package dma_h2c_crdt_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 512;
    localparam int KEEP_W = DATA_W / 8;
    localparam int TUSR_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [TUSR_W-1:0] usr;
    } beat_t;

    // Even parity per byte: bit i is the XOR of byte i.
    function automatic logic [KEEP_W-1:0] byte_parity(input logic [DATA_W-1:0] d);
        logic [KEEP_W-1:0] p;
        p = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dma_h2c_crdt_cnt.sv
// Per-channel credit counter: +1 on a returned credit, -1 on an accepted beat.
// Saturates at all-ones and flags a sticky overflow on a credit that cannot be held.
module dma_h2c_crdt_cnt #(
    parameter int CRDT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [CRDT_W-1:0] cnt_o,
    output logic              ovf_o
);

    logic [CRDT_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (inc_i && !dec_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CRDT_W'(1);
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CRDT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/dma_h2c_crdt_tx.sv
// Credit-gated H2C transmitter: round-robin whole-packet arbitration over four
// AXI-Stream sources, one credit per beat, registered output with byte parity.
module dma_h2c_crdt_tx
    import dma_h2c_crdt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CRDT_W = 8,
    parameter int DATA_W = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*DATA_W-1:0]   s_tdata,
    input  logic [NUM_CH*DATA_W/8-1:0] s_tkeep,
    input  logic [NUM_CH-1:0]          s_tlast,
    input  logic [NUM_CH*64-1:0]       s_tusr,
    input  logic [NUM_CH-1:0]          s_tvalid,
    output logic [NUM_CH-1:0]          s_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic [DATA_W/8-1:0]        m_tparity,
    output logic                       m_tlast,
    output logic [DATA_W/8-1:0]        m_tkeep,
    output logic [63:0]                m_tusr,
    output logic                       m_tvalid,
    output logic [1:0]                 m_tch,
    input  logic                       m_crdt,
    input  logic [1:0]                 m_crdt_ch,
    output logic [NUM_CH*CRDT_W-1:0]   crdt_cnt,
    output logic                       crdt_ovf
);

    logic [CRDT_W-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] dec;
    logic [NUM_CH-1:0] ovf;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            dma_h2c_crdt_cnt #(.CRDT_W(CRDT_W)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc_i (m_crdt && (m_crdt_ch == CH_W'(gi))),
                .dec_i (dec[gi]),
                .cnt_o (cnt[gi]),
                .ovf_o (ovf[gi])
            );
            // Registered count gates eligibility, so a returned credit is usable next cycle.
            assign elig[gi] = s_tvalid[gi] && (cnt[gi] != '0);
            assign crdt_cnt[gi*CRDT_W +: CRDT_W] = cnt[gi];
        end
    endgenerate

    assign crdt_ovf = |ovf;

    arb_state_e      state_q, state_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
    logic [CH_W-1:0] rr_q, rr_d;
    logic            grant_vld;
    logic [CH_W-1:0] grant_ch;
    logic [CH_W-1:0] idx;
    beat_t           sel_beat;

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = lock_ch_q;
        idx       = '0;
        if (state_q == ST_LOCK) begin
            grant_vld = elig[lock_ch_q];
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = rr_q + CH_W'(i);
                if (!grant_vld && elig[idx]) begin
                    grant_vld = 1'b1;
                    grant_ch  = idx;
                end
            end
        end
        if (rst) begin
            grant_vld = 1'b0;
        end
    end

    assign s_tready = grant_vld ? (NUM_CH'(1) << grant_ch) : '0;
    assign dec      = s_tvalid & s_tready;

    always_comb begin
        sel_beat.data = s_tdata[grant_ch*DATA_W +: DATA_W];
        sel_beat.keep = s_tkeep[grant_ch*KEEP_W +: KEEP_W];
        sel_beat.last = s_tlast[grant_ch];
        sel_beat.usr  = s_tusr[grant_ch*TUSR_W +: TUSR_W];
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_d      = rr_q;
        if (grant_vld) begin
            if (sel_beat.last) begin
                state_d = ST_IDLE;
                rr_d    = grant_ch + CH_W'(1);
            end else begin
                state_d   = ST_LOCK;
                lock_ch_d = grant_ch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lock_ch_q <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_q      <= rr_d;
        end
    end

    beat_t             out_q;
    logic [KEEP_W-1:0] par_q;
    logic              vld_q;
    logic [CH_W-1:0]   tch_q;

    // Payload only loads on an accept; the valid strobe drops every idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            par_q <= '0;
            vld_q <= 1'b0;
            tch_q <= '0;
        end else begin
            vld_q <= grant_vld;
            if (grant_vld) begin
                out_q <= sel_beat;
                par_q <= byte_parity(sel_beat.data);
                tch_q <= grant_ch;
            end
        end
    end

    assign m_tdata   = out_q.data;
    assign m_tkeep   = out_q.keep;
    assign m_tlast   = out_q.last;
    assign m_tusr    = out_q.usr;
    assign m_tparity = par_q;
    assign m_tvalid  = vld_q;
    assign m_tch     = tch_q;

endmodule

// File: doc/dma_h2c_crdt_tx.md
Name: dma_h2c_crdt_tx

Overview:
Credit-gated H2C stream transmitter. It sits directly upstream of the H2C credit-interface consumer, whose master-side interface it drives.
- Accepts four per-channel AXI-Stream sources (512-bit data).
- Tracks per-channel credits returned by the consumer.
- Arbitrates whole packets round-robin.
- Emits beats with byte parity and channel tag.
- One credit = one beat.

Parameters:
NUM_CH, 4, number of channels (tch/crdt_ch width = 2; only 4 supported)
CRDT_W, 8, per-channel credit counter width
DATA_W, 512, beat data width; tkeep/tparity width = DATA_W/8

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
s_tdata  in  NUM_CH*512  per-channel data, channel c at [c*512 +: 512]
s_tkeep  in  NUM_CH*64  per-channel byte enables
s_tlast  in  NUM_CH  per-channel end of packet
s_tusr  in  NUM_CH*64  per-channel sideband, passed through
s_tvalid  in  NUM_CH  per-channel valid
s_tready  out  NUM_CH  per-channel ready
m_tdata  out  512  beat to consumer
m_tparity  out  64  even byte parity of m_tdata
m_tlast  out  1  end of packet
m_tkeep  out  64  byte enables
m_tusr  out  64  sideband
m_tvalid  out  1  beat strobe; no backpressure
m_tch  out  2  channel of beat
m_crdt  in  1  one credit returned this cycle
m_crdt_ch  in  2  channel of returned credit
crdt_cnt  out  NUM_CH*CRDT_W  current credit count per channel
crdt_ovf  out  1  sticky: credit return on a saturated counter

Behaviour:
- Reset values: all credit counters 0; m_tvalid, m_tlast 0; m_tch 0; m_tdata, m_tkeep, m_tparity, m_tusr 0; s_tready 0; crdt_ovf 0; RR pointer at ch0; lock cleared.
- Credit counter update, per channel c, registered:
  - next = cnt + inc - dec.
  - inc = m_crdt && m_crdt_ch==c.
  - dec = beat accepted from channel c this cycle.
  - Simultaneous inc and dec on one channel leaves the count unchanged.
  - inc when cnt is all-ones and dec=0: counter holds at max and crdt_ovf sets. crdt_ovf is sticky until rst.
- Eligibility: channel c is eligible when s_tvalid[c]=1 and cnt[c]!=0. Use the registered count; a credit returned in cycle t is usable in t+1.
- Arbitration states:
  - IDLE: pick the first eligible channel at or after the RR pointer, wrapping. Grant in the same cycle; go to LOCK unless the granted beat has tlast.
  - LOCK(ch): only the locked channel may be granted. It needs s_tvalid and cnt!=0; otherwise stall with no switch. Return to IDLE after the tlast beat is accepted.
  - On each packet end, RR pointer = granted ch + 1 mod 4. A single-beat packet updates the pointer in the same cycle.
- s_tready[c] is combinational: 1 only for the granted channel in the cycle it is granted. At most one bit is set. Accept = s_tvalid[c] && s_tready[c].
- Output register: an accepted beat at cycle t appears on m_* with m_tvalid=1 at t+1. Latency is 1, and full throughput of one beat/cycle is supported.
- m_tvalid=0 in non-accept cycles. m_tdata etc. may hold stale values but are don't-care.
- Parity: m_tparity[i] = XOR of m_tdata[8i+7:8i]. Computed on the input side and registered with the data.
- Credits never underflow by construction; dec only occurs when cnt!=0.
- A reset mid-packet drops the lock and zeroes credits. No partial beat is emitted after rst is sampled; m_tvalid=0 on the next cycle.

Decomposition:
- Package dma_h2c_crdt_pkg: NUM_CH, CH_W=2, DATA_W, KEEP_W, TUSR_W=64, arbitration state enum {IDLE, LOCK}, beat struct {data, keep, last, usr}.
- One sub-module, dma_h2c_crdt_cnt, instantiated per channel: credit counter with inc/dec/saturate/ovf.
- Arbiter and output register stay in the top.

Test Plan:
- Reset, no credits, ch0 valid 3-beat packet -> s_tready=0, m_tvalid stays 0; crdt_cnt all 0.
- Return 3 credits to ch2 on consecutive cycles; ch2 sends a 3-beat packet -> beats on m_* 1 cycle after each accept, m_tch=2, last beat m_tlast=1, crdt_cnt[2]=0 after.
- All channels valid, each with 4 credits and single-beat packets -> m_tch order 0,1,2,3,0 ...
- ch1 mid-packet with credits exhausted while ch3 is eligible -> output stalls and no ch3 beat appears; 1 credit to ch1 -> next beat is ch1.
- m_crdt to ch0 in the same cycle ch0 consumes a beat with cnt=5 -> cnt stays 5. Credit to ch0 at cnt=255 -> cnt=255, crdt_ovf=1.
- m_tdata byte0=0x07, byte1=0x03, others 0 -> m_tparity[0]=1, m_tparity[1]=0, others 0.
